// File: rtl/m65c02_msu_if.sv
// m65c02_msu_if: request/result bundle between the microprogram controller
// (master) and the multi-cycle shift/rotate sequencer (slave).
//
// Handshake: the master raises Start for one cycle while Busy=0. The slave
// latches D/Ci/Cnt/Mode/Asr on that edge and holds Busy=1 until the result is
// final. Done=1 marks the single cycle in which Q/Co/OV are final. Start
// while Busy=1 is ignored.
interface m65c02_msu_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             Start;
    logic [1:0]       Mode;
    logic             Asr;
    logic [WIDTH-1:0] D;
    logic             Ci;
    logic [CNT_W-1:0] Cnt;
    logic [WIDTH-1:0] Q;
    logic             Co;
    logic             OV;
    logic             N;
    logic             Z;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Mode, Asr, D, Ci, Cnt,
        input  Q, Co, OV, N, Z, Busy, Done
    );

    modport slave (
        input  Start, Mode, Asr, D, Ci, Cnt,
        output Q, Co, OV, N, Z, Busy, Done
    );
endinterface

// File: rtl/m65c02_msu.sv
// m65c02_msu: iterative shift/rotate sequencer. It performs one single-bit
// ASL/ROL/LSR/ROR step per clock for Cnt clocks, then pulses Done.
// Optional macro M65C02_MSU_ASR_EN: when defined, Mode=2'b10 with Asr=1
// performs an arithmetic right shift (sign bit replicated). When undefined,
// Asr is ignored and no ASR logic exists.
module m65c02_msu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    m65c02_msu_if.slave        bus,
    output logic [1:0]         dbg_state_o
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] q_q;
    logic             co_q;
    logic             ov_q;
    logic [1:0]       mode_q;
`ifdef M65C02_MSU_ASR_EN
    logic             asr_q;
`endif

    logic [WIDTH-1:0] q_d;
    logic             co_d;
    logic             ov_d;

    // Result of one single-bit step applied to the current Q/Co/OV.
    always_comb begin
        q_d  = q_q;
        co_d = co_q;
        ov_d = ov_q;
        case (mode_q)
            2'b00: begin
                co_d = q_q[MSB];
                q_d  = {q_q[MSB-1:0], 1'b0};
                ov_d = ov_q | (q_q[MSB] ^ q_q[MSB-1]);
            end
            2'b01: begin
                {co_d, q_d} = {q_q, co_q};
                ov_d = ov_q | (q_q[MSB] ^ q_q[MSB-1]);
            end
            2'b10: begin
                co_d = q_q[0];
`ifdef M65C02_MSU_ASR_EN
                q_d  = {asr_q & q_q[MSB], q_q[MSB:1]};
`else
                q_d  = {1'b0, q_q[MSB:1]};
`endif
            end
            default: begin
                {q_d, co_d} = {co_q, q_q};
            end
        endcase
    end

    // Sequencer: load on Start in IDLE, step while the counter runs, then one
    // DONE cycle. Reset aborts any operation without a Done pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            mode_q  <= 2'b00;
`ifdef M65C02_MSU_ASR_EN
            asr_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        q_q    <= bus.D;
                        co_q   <= bus.Ci;
                        ov_q   <= 1'b0;
                        mode_q <= bus.Mode;
`ifdef M65C02_MSU_ASR_EN
                        asr_q  <= bus.Asr;
`endif
                        cnt_q  <= bus.Cnt;
                        state_q <= (bus.Cnt != '0) ? S_SHIFT : S_DONE;
                    end
                end
                S_SHIFT: begin
                    q_q   <= q_d;
                    co_q  <= co_d;
                    ov_q  <= ov_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Q       = q_q;
    assign bus.Co      = co_q;
    assign bus.OV      = ov_q;
    assign bus.N       = q_q[MSB];
    assign bus.Z       = (q_q == '0);
    assign bus.Busy    = (state_q != S_IDLE);
    assign bus.Done    = (state_q == S_DONE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_m65c02_msu.sv
// tb_m65c02_msu: randomized and directed checks of m65c02_msu against a
// closed-form reference model (shifts and ring rotations on whole words).
module tb_m65c02_msu;
    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    m65c02_msu_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    m65c02_msu #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk         (clk),
        .Rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard: {OV, Co, Q}
    logic [17:0] exp_q[$];

    // observations from the driver
    int          obs_done_at;
    int          obs_busy;
    logic [15:0] obs_q;
    logic        obs_co, obs_ov, obs_n, obs_z;
    logic        obs_after_busy, obs_after_done;
    logic [15:0] obs_after_q;
    logic [15:0] qtrace[64];

    // ---------------- reference model ----------------
    function automatic logic [16:0] rotl17(input logic [16:0] v, input int r);
        logic [33:0] t;
        t = {v, v} << (r % 17);
        return t[33:17];
    endfunction

    function automatic logic [16:0] rotr17(input logic [16:0] v, input int r);
        logic [33:0] t;
        t = {v, v} >> (r % 17);
        return t[16:0];
    endfunction

    function automatic logic [17:0] model(input logic [15:0] d, input logic ci,
                                          input logic [1:0] mode, input logic asr,
                                          input int c);
        logic [15:0] q;
        logic co, ov;
        logic [63:0] full, pre;
        logic [16:0] rv;
        logic signed [31:0] s, st;
        logic [31:0] u;
        bit use_asr;
        q = d; co = ci; ov = 1'b0;
`ifdef M65C02_MSU_ASR_EN
        use_asr = asr;
`else
        use_asr = 1'b0;
`endif
        case (mode)
            2'b00: begin
                full = 64'(d) << c;
                q = full[15:0];
                if (c > 0) co = full[16];
                for (int i = 0; i < c; i++) begin
                    pre = 64'(d) << i;
                    if (pre[15] != pre[14]) ov = 1'b1;
                end
            end
            2'b01: begin
                rv = rotl17({ci, d}, c);
                q = rv[15:0];
                co = rv[16];
                for (int i = 0; i < c; i++) begin
                    rv = rotl17({ci, d}, i);
                    if (rv[15] != rv[14]) ov = 1'b1;
                end
            end
            2'b10: begin
                if (use_asr) begin
                    s = {{16{d[15]}}, d};
                    st = s >>> c;
                    q = st[15:0];
                    if (c > 0) begin
                        st = s >>> (c - 1);
                        co = st[0];
                    end
                end else begin
                    u = 32'(d);
                    q = 16'(u >> c);
                    if (c > 0) co = u[c-1];
                end
            end
            default: begin
                rv = rotr17({d, ci}, c);
                q = rv[16:1];
                co = rv[0];
            end
        endcase
        return {ov, co, q};
    endfunction

    // ---------------- driver ----------------
    // Issues one request; poke=1 also strobes Start with a different operand
    // while the sequencer is busy.
    task automatic run_op(input logic [15:0] d, input logic ci, input logic [1:0] mode,
                          input logic asr, input int cnt, input bit poke);
        @(negedge clk);
        bus.D = d; bus.Ci = ci; bus.Mode = mode; bus.Asr = asr;
        bus.Cnt = CNT_W'(cnt); bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.D = 16'($urandom); bus.Ci = 1'($urandom); bus.Mode = 2'($urandom);
        bus.Asr = 1'($urandom); bus.Cnt = CNT_W'($urandom);
        obs_done_at = -1;
        obs_busy = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            qtrace[n] = bus.Q;
            if (poke && n == 1) begin
                bus.D = ~d; bus.Ci = ~ci; bus.Cnt = CNT_W'(1); bus.Start = 1'b1;
            end
            if (poke && n == 2) bus.Start = 1'b0;
            if (bus.Busy) obs_busy++;
            if (bus.Done) begin
                obs_done_at = n;
                obs_q = bus.Q; obs_co = bus.Co; obs_ov = bus.OV;
                obs_n = bus.N; obs_z = bus.Z;
                break;
            end
        end
        bus.Start = 1'b0;
        @(negedge clk);
        obs_after_busy = bus.Busy;
        obs_after_done = bus.Done;
        obs_after_q = bus.Q;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.Busy, bus.Done, bus.Q, bus.Co, bus.OV, bus.Z, bus.N} !== {2'b00, 16'h0000, 2'b00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b q=%h co=%b ov=%b z=%b n=%b, want 0 0 0000 0 0 1 0",
                     bus.Busy, bus.Done, bus.Q, bus.Co, bus.OV, bus.Z, bus.N);
        end
    endtask

    task automatic test_asl();
        run_op(16'h8001, 1'b0, 2'b00, 1'b0, 1, 1'b0);
        checks++;
        if ({obs_q, obs_co, obs_ov} !== {16'h0002, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL asl: got q=%h co=%b ov=%b, want 0002 1 1", obs_q, obs_co, obs_ov);
        end
        checks++;
        if (obs_done_at !== 1 || obs_busy !== 2) begin
            errors++;
            $display("FAIL asl_timing: got done_at=%0d busy=%0d, want 1 2", obs_done_at, obs_busy);
        end
    endtask

    task automatic test_rol();
        logic [15:0] want[4];
        want[0] = 16'h0003; want[1] = 16'h0006; want[2] = 16'h000C; want[3] = 16'h0018;
        run_op(16'h0001, 1'b1, 2'b01, 1'b0, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (qtrace[i+1] !== want[i]) begin
                errors++;
                $display("FAIL rol_step%0d: got q=%h, want %h", i + 1, qtrace[i+1], want[i]);
            end
        end
        checks++;
        if ({obs_co, obs_ov} !== 2'b00 || obs_done_at !== 4 || obs_busy !== 5) begin
            errors++;
            $display("FAIL rol_final: got co=%b ov=%b done_at=%0d busy=%0d, want 0 0 4 5",
                     obs_co, obs_ov, obs_done_at, obs_busy);
        end
    endtask

    task automatic test_ror_zero();
        run_op(16'h0001, 1'b0, 2'b11, 1'b0, 1, 1'b0);
        checks++;
        if ({obs_q, obs_co, obs_z} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ror: got q=%h co=%b z=%b, want 0000 1 1", obs_q, obs_co, obs_z);
        end
        run_op(16'h1234, 1'b1, 2'b11, 1'b0, 0, 1'b0);
        checks++;
        if ({obs_q, obs_co, obs_ov} !== {16'h1234, 1'b1, 1'b0} || obs_done_at !== 0 || obs_busy !== 1) begin
            errors++;
            $display("FAIL zero_cnt: got q=%h co=%b ov=%b done_at=%0d busy=%0d, want 1234 1 0 0 1",
                     obs_q, obs_co, obs_ov, obs_done_at, obs_busy);
        end
    endtask

    task automatic test_busy_ignore();
        logic [17:0] e;
        e = model(16'hC3A5, 1'b1, 2'b01, 1'b0, 6);
        run_op(16'hC3A5, 1'b1, 2'b01, 1'b0, 6, 1'b1);
        checks++;
        if ({obs_ov, obs_co, obs_q} !== e || obs_done_at !== 6) begin
            errors++;
            $display("FAIL busy_ignore: got ov/co/q=%h done_at=%0d, want %h 6",
                     {obs_ov, obs_co, obs_q}, obs_done_at, e);
        end
        checks++;
        if (obs_after_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_idle: got busy=%b after done, want 0", obs_after_busy);
        end
    endtask

    task automatic test_abort();
        int dones;
        @(negedge clk);
        bus.D = 16'hBEEF; bus.Ci = 1'b1; bus.Mode = 2'b00; bus.Cnt = CNT_W'(8); bus.Start = 1'b1;
        @(posedge clk);            // edge k
        #1 bus.Start = 1'b0;
        @(negedge clk);            // after edge k
        @(negedge clk);            // after edge k+1
        rst = 1'b1;                // sampled at edge k+2
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.Busy, bus.Done, bus.Q, bus.Co, bus.OV} !== {2'b00, 16'h0000, 2'b00}) begin
            errors++;
            $display("FAIL abort_state: got busy=%b done=%b q=%h co=%b ov=%b, want 0 0 0000 0 0",
                     bus.Busy, bus.Done, bus.Q, bus.Co, bus.OV);
        end
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_nodone: got %0d busy/done cycles after abort, want 0", dones);
        end
    endtask

    task automatic test_asr_macro();
        logic [15:0] wq;
        logic wn;
`ifdef M65C02_MSU_ASR_EN
        wq = 16'hE001; wn = 1'b1;
`else
        wq = 16'h2001; wn = 1'b0;
`endif
        run_op(16'h8004, 1'b0, 2'b10, 1'b1, 2, 1'b0);
        checks++;
        if ({obs_q, obs_co, obs_n, obs_ov} !== {wq, 1'b0, wn, 1'b0}) begin
            errors++;
            $display("FAIL asr_macro: got q=%h co=%b n=%b ov=%b, want %h 0 %b 0",
                     obs_q, obs_co, obs_n, obs_ov, wq, wn);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic ci, asr;
        logic [1:0] mode;
        int c;
        logic [17:0] e;
        for (int t = 0; t < 40; t++) begin
            d = 16'($urandom);
            ci = 1'($urandom);
            mode = 2'($urandom);
            asr = 1'($urandom);
            c = (t % 10 == 9) ? 31 : int'($urandom_range(0, 20));
            exp_q.push_back(model(d, ci, mode, asr, c));
            run_op(d, ci, mode, asr, c, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({obs_ov, obs_co, obs_q} !== e || obs_n !== e[15] || obs_z !== (e[15:0] == 16'h0)) begin
                errors++;
                $display("FAIL rand%0d: mode=%b d=%h ci=%b c=%0d got ov/co/q=%h n=%b z=%b, want %h",
                         t, mode, d, ci, c, {obs_ov, obs_co, obs_q}, obs_n, obs_z, e);
            end
            checks++;
            if (obs_done_at !== c || obs_busy !== c + 1 || obs_after_done !== 1'b0 ||
                obs_after_busy !== 1'b0 || obs_after_q !== e[15:0]) begin
                errors++;
                $display("FAIL rand%0d_timing: got done_at=%0d busy=%0d after_done=%b after_busy=%b hold_q=%h, want %0d %0d 0 0 %h",
                         t, obs_done_at, obs_busy, obs_after_done, obs_after_busy, obs_after_q,
                         c, c + 1, e[15:0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.Start = 1'b0; bus.Mode = 2'b00; bus.Asr = 1'b0;
        bus.D = '0; bus.Ci = 1'b0; bus.Cnt = '0;
        test_reset();
        test_asl();
        test_rol();
        test_ror_zero();
        test_busy_ignore();
        test_abort();
        test_asr_macro();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/m65c02_msu.md
# m65c02_msu

Multi-cycle shift/rotate sequencer for the M65C02A extended-width datapath. It is the iterative, multi-bit counterpart of the core's single-step shift unit. The block accepts a WIDTH-bit operand, a carry-in and a shift count on a one-cycle Start strobe. It then performs one single-bit ASL/ROL/LSR/ROR step per clock and returns the result, carry-out and flags with a one-cycle Done pulse. It sits beside the ALU and is sequenced by the microprogram controller, which waits on Busy/Done.

## Interface

Clocking and reset (already decided): one clock, `Clk`; reset `Rst` is synchronous and active-high.

Parameters:
- WIDTH, 16, operand/result width (≥ 2)
- CNT_W, 5, shift-count width; maximum count 2^CNT_W − 1

Ports:
- Clk  in  1  system clock; all state changes on rising edge
- Rst  in  1  synchronous active-high reset
- Start  in  1  request strobe; sampled only in IDLE
- Mode  in  2  Mode[1]=direction (0 left, 1 right), Mode[0]=rotate through carry
- Asr  in  1  arithmetic right shift select (effective only with macro, Mode=2'b10)
- D  in  WIDTH  operand
- Ci  in  1  carry-in
- Cnt  in  CNT_W  number of single-bit steps
- Q  out  WIDTH  result register
- Co  out  1  carry-out register
- OV  out  1  sticky sign-change flag, registered
- N  out  1  Q[WIDTH-1], combinational
- Z  out  1  (Q == 0), combinational
- Busy  out  1  state ≠ IDLE
- Done  out  1  one-cycle completion pulse

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE with Start=1:
  - Load Q←D, Co←Ci, OV←0.
  - Latch Mode, Asr and the step counter ← Cnt.
  - Next state is SHIFT if Cnt≠0, else DONE.
- SHIFT: one step per clock; decrement the counter; go to DONE on the step that brings it to 0.
- DONE: Done=1 for one cycle, then IDLE.
- Step definitions (MSB = WIDTH−1):
  - ASL (00): Co←Q[MSB], Q←{Q[MSB-1:0],0}.
  - ROL (01): {Co,Q}←{Q,Co}, a (WIDTH+1)-bit ring.
  - LSR (10): Co←Q[0], Q←{0,Q[MSB:1]}.
  - ROR (11): {Q,Co}←{Co,Q}.
- OV: on each left step, OV←OV | (Q[MSB]^Q[MSB-1]) evaluated before the step. OV is never set by right steps.
- Start is ignored in SHIFT and DONE; latched operands are not disturbed.
- Q, Co and OV hold their values in IDLE until the next accepted Start.
- Rst in any state, including mid-SHIFT: state→IDLE, Q←0, Co←0, OV←0, counter←0. No Done pulse is produced for the aborted operation.

## Timing

- Reset values: Busy=0, Done=0, Q=0, Co=0, OV=0, N=0, Z=1.
- Start sampled at edge k with count c:
  - Q/Co update at edges k+1 … k+c.
  - Done=1 in the cycle following edge k+c, with the final Q/Co/OV valid in that same cycle.
  - Busy=1 in the cycles following edges k … k+c, i.e. c+1 cycles.
- c=0: Done follows edge k directly; Q=D, Co=Ci, OV=0.
- Earliest next accepted Start is the first IDLE cycle after Done, sampled at edge k+c+2. Throughput is one operation per c+2 cycles.
- Maximum latency is 2^CNT_W − 1 steps.

## Configuration

- Macro `M65C02_MSU_ASR_EN`.
- Defined: Mode=2'b10 with Asr=1 performs an arithmetic right step: Co←Q[0], Q←{Q[MSB],Q[MSB:1]}. OV stays 0.
- Not defined: the Asr input is ignored and Mode=2'b10 is always LSR. No ASR logic is synthesized.

## Test plan

- Reset: assert Rst for 2 cycles → Busy=0, Done=0, Q=16'h0000, Co=0, OV=0, Z=1, N=0.
- ASL: D=16'h8001, Ci=0, Cnt=1, Start at edge k → Done after edge k+1, Q=16'h0002, Co=1, OV=1, Busy high for 2 cycles.
- ROL: D=16'h0001, Ci=1, Cnt=4 → Q after successive steps 0003, 0006, 000C, 0018; final Co=0, OV=0; Done after edge k+4; Busy high for 5 cycles.
- ROR and zero count:
  - D=16'h0001, Ci=0, Cnt=1 → Q=16'h0000, Co=1, Z=1.
  - Then D=16'h1234, Ci=1, Cnt=0 → Done after edge k, Q=16'h1234, Co=1.
- Busy and abort:
  - Start with new D while in SHIFT → ignored; result matches the first request.
  - Rst at edge k+2 of a Cnt=8 operation → IDLE, Q=0, no Done pulse.
- Macro: D=16'h8004, Mode=2'b10, Asr=1, Cnt=2:
  - With `M65C02_MSU_ASR_EN` → Q=16'hE001, Co=0, N=1.
  - Without it → Q=16'h2001, Co=0, N=0.
